cxd_sector_sequencer: RTL and testbench

- Paces the CXD2545 emulator's audio/data output stream in whole CD sectors.
- Counts LRCK frames, requests each next sector from the DMA/drain side with a req/ack handshake, and emits the sector-boundary strobes: SCOR pulse and SubQ reload.
- Drives C2PO/mute when the buffer starves.
- Sits between the CPU-side sector fetcher and the serializer/SubQ output blocks, in the CPU_CLK domain.

---
 rtl/cxd_sector_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_cxd_sector_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cxd_sector_sequencer.sv
// rtl/cxd_sector_sequencer.sv - CD sector pacing: LRCK frame count, sector fetch handshake, SCOR/SubQ strobes
module cxd_sector_sequencer #(
    parameter int FRAMES_PER_SECTOR = 588,
    parameter int REQ_LEAD          = 98,
    parameter int SCOR_WIDTH        = 64,
    parameter int LBA_W             = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             lrck,
    input  logic             seek_valid,
    input  logic [LBA_W-1:0] seek_lba,
    output logic             sect_req,
    output logic [LBA_W-1:0] sect_lba,
    input  logic             sect_ack,
    output logic             scor,
    output logic             subq_load,
    output logic             c2po,
    output logic             mute,
    output logic [LBA_W-1:0] cur_lba,
    output logic [9:0]       frame_idx,
    output logic [15:0]      underrun_cnt
);

    localparam int             SCW        = $clog2(SCOR_WIDTH + 1);
    localparam logic [9:0]     LAST_FRAME = 10'(FRAMES_PER_SECTOR - 1);
    localparam logic [9:0]     REQ_FRAME  = 10'(FRAMES_PER_SECTOR - REQ_LEAD);
    localparam logic [SCW-1:0] SCOR_LOAD  = SCW'(SCOR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SYNC  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_lrck_q;
    logic             r_sect_req;
    logic             r_subq_load;
    logic             r_c2po;
    logic             r_mute;
    logic             r_scor;
    logic [SCW-1:0]   r_scor_cnt;
    logic [LBA_W-1:0] r_cur_lba;
    logic [LBA_W-1:0] r_next_lba;
    logic [9:0]       r_frame_idx;
    logic [15:0]      r_underrun_cnt;
    logic             r_ready;

    state_t           w_state_nxt;
    logic             w_sect_req_nxt;
    logic             w_subq_load_nxt;
    logic             w_c2po_nxt;
    logic             w_mute_nxt;
    logic [SCW-1:0]   w_scor_cnt_nxt;
    logic [LBA_W-1:0] w_cur_lba_nxt;
    logic [LBA_W-1:0] w_next_lba_nxt;
    logic [9:0]       w_frame_idx_nxt;
    logic [15:0]      w_underrun_nxt;
    logic             w_ready_nxt;
    logic             w_tick;
    logic             w_ack;
    logic             w_start;

    // An ack only means something while a request is outstanding.
    assign w_tick = lrck & ~r_lrck_q;
    assign w_ack  = sect_ack & r_sect_req;

    // Next-state and register-input decode; priority is enable=0, then seek, then ack, then tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_sect_req_nxt  = r_sect_req;
        w_subq_load_nxt = 1'b0;
        w_c2po_nxt      = r_c2po;
        w_mute_nxt      = r_mute;
        w_scor_cnt_nxt  = (r_scor_cnt != '0) ? (r_scor_cnt - SCW'(1)) : r_scor_cnt;
        w_cur_lba_nxt   = r_cur_lba;
        w_next_lba_nxt  = r_next_lba;
        w_frame_idx_nxt = r_frame_idx;
        w_underrun_nxt  = r_underrun_cnt;
        w_ready_nxt     = r_ready;
        w_start         = 1'b0;

        if (!enable) begin
            // Disabled: drop any buffered-but-unstarted sector so re-enable refetches next_lba.
            w_state_nxt    = ST_IDLE;
            w_sect_req_nxt = 1'b0;
            w_c2po_nxt     = 1'b1;
            w_mute_nxt     = 1'b1;
            w_scor_cnt_nxt = '0;
            w_ready_nxt    = 1'b0;
            if (seek_valid) begin
                w_next_lba_nxt = seek_lba;
            end
        end else if (seek_valid) begin
            // Seek abandons the pending request; FETCH re-raises it one cycle later.
            w_next_lba_nxt = seek_lba;
            w_ready_nxt    = 1'b0;
            w_sect_req_nxt = 1'b0;
            w_c2po_nxt     = 1'b1;
            w_mute_nxt     = 1'b1;
            w_state_nxt    = ST_FETCH;
        end else begin
            if (w_ack) begin
                w_sect_req_nxt = 1'b0;
                w_ready_nxt    = 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt    = ST_FETCH;
                    w_sect_req_nxt = 1'b1;
                end
                ST_FETCH: begin
                    if (w_ack) begin
                        w_state_nxt = ST_SYNC;
                    end else begin
                        w_sect_req_nxt = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_tick) begin
                        w_start = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        if (r_frame_idx == LAST_FRAME) begin
                            if (r_ready || w_ack) begin
                                w_start = 1'b1;
                            end else begin
                                // Starved: flag invalid samples and keep the outstanding request alive.
                                if (r_underrun_cnt != 16'hFFFF) begin
                                    w_underrun_nxt = r_underrun_cnt + 16'd1;
                                end
                                w_c2po_nxt      = 1'b1;
                                w_mute_nxt      = 1'b1;
                                w_frame_idx_nxt = '0;
                                w_sect_req_nxt  = 1'b1;
                                w_state_nxt     = ST_FETCH;
                            end
                        end else begin
                            w_frame_idx_nxt = r_frame_idx + 10'd1;
                            if ((r_frame_idx + 10'd1) == REQ_FRAME) begin
                                w_sect_req_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            if (w_start) begin
                w_frame_idx_nxt = '0;
                w_cur_lba_nxt   = r_next_lba;
                w_next_lba_nxt  = r_next_lba + LBA_W'(1);
                w_ready_nxt     = 1'b0;
                w_scor_cnt_nxt  = SCOR_LOAD;
                w_subq_load_nxt = 1'b1;
                w_c2po_nxt      = 1'b0;
                w_mute_nxt      = 1'b0;
                w_state_nxt     = ST_PLAY;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_lrck_q       <= 1'b0;
            r_sect_req     <= 1'b0;
            r_subq_load    <= 1'b0;
            r_c2po         <= 1'b1;
            r_mute         <= 1'b1;
            r_scor         <= 1'b0;
            r_scor_cnt     <= '0;
            r_cur_lba      <= '0;
            r_next_lba     <= '0;
            r_frame_idx    <= '0;
            r_underrun_cnt <= '0;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_lrck_q       <= lrck;
            r_sect_req     <= w_sect_req_nxt;
            r_subq_load    <= w_subq_load_nxt;
            r_c2po         <= w_c2po_nxt;
            r_mute         <= w_mute_nxt;
            r_scor         <= (w_scor_cnt_nxt != '0);
            r_scor_cnt     <= w_scor_cnt_nxt;
            r_cur_lba      <= w_cur_lba_nxt;
            r_next_lba     <= w_next_lba_nxt;
            r_frame_idx    <= w_frame_idx_nxt;
            r_underrun_cnt <= w_underrun_nxt;
            r_ready        <= w_ready_nxt;
        end
    end

    assign sect_req     = r_sect_req;
    assign sect_lba     = r_next_lba;
    assign scor         = r_scor;
    assign subq_load    = r_subq_load;
    assign c2po         = r_c2po;
    assign mute         = r_mute;
    assign cur_lba      = r_cur_lba;
    assign frame_idx    = r_frame_idx;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_cxd_sector_sequencer.sv
// tb/tb_cxd_sector_sequencer.sv - self-checking bench for cxd_sector_sequencer
module tb_cxd_sector_sequencer;

    localparam int F  = 8;
    localparam int RL = 3;
    localparam int SW = 4;
    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          lrck = 1'b0;
    logic          seek_valid = 1'b0;
    logic [LW-1:0] seek_lba = '0;
    logic          ack_auto = 1'b0;
    logic          ack_man = 1'b0;
    logic          sect_ack;
    logic          sect_req;
    logic [LW-1:0] sect_lba;
    logic          scor;
    logic          subq_load;
    logic          c2po;
    logic          mute;
    logic [LW-1:0] cur_lba;
    logic [9:0]    frame_idx;
    logic [15:0]   underrun_cnt;

    assign sect_ack = ack_auto | ack_man;

    cxd_sector_sequencer #(
        .FRAMES_PER_SECTOR(F),
        .REQ_LEAD(RL),
        .SCOR_WIDTH(SW),
        .LBA_W(LW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .lrck(lrck),
        .seek_valid(seek_valid),
        .seek_lba(seek_lba),
        .sect_req(sect_req),
        .sect_lba(sect_lba),
        .sect_ack(sect_ack),
        .scor(scor),
        .subq_load(subq_load),
        .c2po(c2po),
        .mute(mute),
        .cur_lba(cur_lba),
        .frame_idx(frame_idx),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // LRCK: period 20 clk, changed on falling edges
    initial begin
        forever begin
            repeat (10) @(negedge clk);
            lrck = ~lrck;
        end
    end

    int   cyc = 0;
    int   last_tick = -1;
    logic lq = 1'b0;

    // Edge counter and independent record of which edge carried an LRCK rise
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lrck && !lq) last_tick <= cyc + 1;
        lq <= lrck;
    end

    int            n_checks = 0;
    int            n_err = 0;
    logic [LW-1:0] sb_q[$];
    logic          auto_ack = 1'b0;
    logic          scor_cut = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name, input int budget);
        n_checks++;
        n_err++;
        $display("FAIL %s: no event within %0d cycles", name, budget);
    endtask

    // Scoreboard consumer: every sector start must match the oldest acknowledged sector
    initial begin
        logic          prev_c2po;
        logic [9:0]    prev_frame;
        logic          prev_scor;
        int            scor_w;
        logic [LW-1:0] exp_lba;
        prev_c2po  = 1'b1;
        prev_frame = '0;
        prev_scor  = 1'b0;
        scor_w     = 0;
        forever begin
            @(negedge clk);
            if (subq_load === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL start_expected: started 0x%0h with no sector acknowledged", cur_lba);
                end else begin
                    exp_lba = sb_q.pop_front();
                    chk("start_cur_lba", 32'(cur_lba), 32'(exp_lba));
                end
                chk("start_scor", 32'(scor), 32'(1));
                chk("start_c2po", 32'(c2po), 32'(0));
                chk("start_mute", 32'(mute), 32'(0));
                chk("start_frame", 32'(frame_idx), 32'(0));
                chk("start_on_tick", 32'(last_tick), 32'(cyc));
                if (!prev_c2po) chk("boundary_prev_frame", 32'(prev_frame), 32'(F - 1));
                scor_cut = 1'b0;
            end
            if (scor === 1'b1) begin
                scor_w++;
            end else begin
                if (prev_scor && !scor_cut) chk("scor_width", 32'(scor_w), 32'(SW));
                scor_w = 0;
            end
            prev_scor  = scor;
            prev_c2po  = c2po;
            prev_frame = frame_idx;
        end
    end

    // Scoreboard producer: acknowledge 5 cycles into each request and expect that sector
    initial begin
        int wait_n;
        wait_n = 0;
        forever begin
            @(negedge clk);
            ack_auto = 1'b0;
            if (auto_ack && sect_req && !reset) begin
                wait_n++;
                if (wait_n == 5) begin
                    ack_auto = 1'b1;
                    sb_q.push_back(sect_lba);
                    wait_n = 0;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    task automatic wait_start(input string name, input int budget, output int waited, output int c2po_low);
        c2po_low = 0;
        for (waited = 1; waited <= budget; waited++) begin
            @(negedge clk);
            if (subq_load === 1'b1) return;
            if (c2po === 1'b0) c2po_low++;
        end
        timeout_fail(name, budget);
    endtask

    task automatic wait_frame(input string name, input logic [9:0] val, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_idx === val) return;
        end
        timeout_fail(name, budget);
    endtask

    task automatic wait_req_rise(input string name, input int budget);
        logic prev;
        prev = sect_req;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sect_req === 1'b1 && prev === 1'b0) return;
            prev = sect_req;
        end
        timeout_fail(name, budget);
    endtask

    task automatic wait_c2po_high(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (c2po === 1'b1) return;
        end
        timeout_fail(name, budget);
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic          seek;
        logic [LW-1:0] slba;
        logic          ack;
        logic          push;
        logic          exp_req;
        logic [LW-1:0] exp_lba;
        logic          exp_c2po;
        logic          exp_mute;
        logic          exp_scor;
        logic [LW-1:0] exp_cur;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int   ack_cyc;
        int   waited;
        int   c2po_low;
        logic found;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 20'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 20'h00100, 1'b0, 1'b0, 1'b0, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 20'h00200, 1'b0, 1'b0, 1'b0, 20'h00200, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 20'h00200, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 20'h00200, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 20'h00200, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 20'h00100, 1'b0, 1'b0, 1'b0, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 20'h00100, 1'b1, 1'b1, 1'b0, 20'h0};

        ack_cyc = 0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            reset      = tbl[i].rst;
            enable     = tbl[i].en;
            seek_valid = tbl[i].seek;
            seek_lba   = tbl[i].slba;
            ack_man    = tbl[i].ack;
            if (tbl[i].push) begin
                sb_q.push_back(tbl[i].exp_lba);
                ack_cyc = cyc;
            end
            @(negedge clk);
            seek_valid = 1'b0;
            ack_man    = 1'b0;
            chk($sformatf("vec%0d_req", i), 32'(sect_req), 32'(tbl[i].exp_req));
            chk($sformatf("vec%0d_lba", i), 32'(sect_lba), 32'(tbl[i].exp_lba));
            chk($sformatf("vec%0d_c2po", i), 32'(c2po), 32'(tbl[i].exp_c2po));
            chk($sformatf("vec%0d_mute", i), 32'(mute), 32'(tbl[i].exp_mute));
            chk($sformatf("vec%0d_scor", i), 32'(scor), 32'(tbl[i].exp_scor));
            chk($sformatf("vec%0d_cur", i), 32'(cur_lba), 32'(tbl[i].exp_cur));
            if (tbl[i].rst) begin
                chk("reset_frame", 32'(frame_idx), 32'(0));
                chk("reset_underrun", 32'(underrun_cnt), 32'(0));
                chk("reset_subq", 32'(subq_load), 32'(0));
            end
        end

        // Basic play: first start on the first LRCK rise after the ack
        auto_ack = 1'b1;
        wait_start("first_start", 40, waited, c2po_low);
        chk("first_start_latency", 32'((cyc - ack_cyc) >= 2 && (cyc - ack_cyc) <= 21), 32'(1));
        wait_req_rise("prefetch1", 200);
        chk("prefetch1_frame", 32'(frame_idx), 32'(F - RL));
        chk("prefetch1_lba", 32'(sect_lba), 32'(20'h00101));
        wait_start("second_start", 200, waited, c2po_low);
        chk("second_cur", 32'(cur_lba), 32'(20'h00101));

        // Underrun: withhold the ack for the next prefetch
        auto_ack = 1'b0;
        wait_req_rise("prefetch2", 200);
        chk("prefetch2_lba", 32'(sect_lba), 32'(20'h00102));
        wait_c2po_high("underrun", 200);
        chk("underrun_cnt1", 32'(underrun_cnt), 32'(1));
        chk("underrun_mute", 32'(mute), 32'(1));
        chk("underrun_scor", 32'(scor), 32'(0));
        chk("underrun_subq", 32'(subq_load), 32'(0));
        chk("underrun_req", 32'(sect_req), 32'(1));
        chk("underrun_lba", 32'(sect_lba), 32'(20'h00102));
        chk("underrun_frame", 32'(frame_idx), 32'(0));
        chk("underrun_on_tick", 32'(last_tick), 32'(cyc));
        repeat (30) @(negedge clk);
        chk("underrun_req_held", 32'(sect_req), 32'(1));
        chk("underrun_c2po_held", 32'(c2po), 32'(1));
        ack_man = 1'b1;
        sb_q.push_back(20'h00102);
        @(negedge clk);
        ack_man = 1'b0;
        chk("underrun_ack_req", 32'(sect_req), 32'(0));
        auto_ack = 1'b1;
        wait_start("recover_start", 40, waited, c2po_low);

        // Seek mid-sector to the top of the address space
        wait_frame("seek_frame3", 10'd3, 200);
        seek_valid = 1'b1;
        seek_lba   = 20'hFFFFF;
        sb_q.delete();
        @(negedge clk);
        seek_valid = 1'b0;
        chk("seek_req_drop", 32'(sect_req), 32'(0));
        chk("seek_c2po", 32'(c2po), 32'(1));
        chk("seek_mute", 32'(mute), 32'(1));
        chk("seek_lba", 32'(sect_lba), 32'(20'hFFFFF));
        @(negedge clk);
        chk("seek_req_again", 32'(sect_req), 32'(1));
        chk("seek_lba_again", 32'(sect_lba), 32'(20'hFFFFF));
        wait_start("seek_start", 60, waited, c2po_low);
        chk("seek_c2po_held", 32'(c2po_low), 32'(0));
        auto_ack = 1'b0;
        wait_req_rise("wrap_prefetch", 200);
        chk("wrap_lba", 32'(sect_lba), 32'(20'h00000));
        chk("wrap_frame", 32'(frame_idx), 32'(F - RL));

        // Ack lands on the same edge as the boundary tick
        wait_frame("sim_frame7", 10'(F - 1), 200);
        found = 1'b0;
        for (int k = 0; k < 45 && !found; k++) begin
            @(negedge clk);
            #1;
            if (lrck && !lq) found = 1'b1;
        end
        if (!found) timeout_fail("sim_align", 45);
        ack_man = 1'b1;
        sb_q.push_back(20'h00000);
        @(negedge clk);
        ack_man = 1'b0;
        chk("sim_start", 32'(subq_load), 32'(1));
        chk("sim_underrun", 32'(underrun_cnt), 32'(1));

        // Disable during the SCOR pulse
        @(negedge clk);
        chk("dis_scor_was_high", 32'(scor), 32'(1));
        scor_cut = 1'b1;
        enable   = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("dis_scor", 32'(scor), 32'(0));
        chk("dis_req", 32'(sect_req), 32'(0));
        chk("dis_c2po", 32'(c2po), 32'(1));
        chk("dis_mute", 32'(mute), 32'(1));
        chk("dis_cur", 32'(cur_lba), 32'(20'h00000));
        chk("dis_next", 32'(sect_lba), 32'(20'h00001));
        enable   = 1'b1;
        auto_ack = 1'b1;
        @(negedge clk);
        chk("reen_req", 32'(sect_req), 32'(1));
        chk("reen_lba", 32'(sect_lba), 32'(20'h00001));
        wait_start("reen_start", 60, waited, c2po_low);

        // Reset mid-PLAY
        wait_frame("rst_frame4", 10'd4, 200);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req", 32'(sect_req), 32'(0));
        chk("rst_scor", 32'(scor), 32'(0));
        chk("rst_subq", 32'(subq_load), 32'(0));
        chk("rst_c2po", 32'(c2po), 32'(1));
        chk("rst_mute", 32'(mute), 32'(1));
        chk("rst_cur", 32'(cur_lba), 32'(0));
        chk("rst_lba", 32'(sect_lba), 32'(0));
        chk("rst_frame", 32'(frame_idx), 32'(0));
        chk("rst_underrun", 32'(underrun_cnt), 32'(0));
        wait_start("rst_restart", 60, waited, c2po_low);

        // Saturation, and a stray ack with nothing requested
        auto_ack = 1'b0;
        force dut.r_underrun_cnt = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.r_underrun_cnt;
        @(negedge clk);
        chk("sat_preset", 32'(underrun_cnt), 32'(16'hFFFF));
        wait_frame("stray_frame2", 10'd2, 200);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        chk("stray_req", 32'(sect_req), 32'(0));
        chk("stray_c2po", 32'(c2po), 32'(0));
        wait_c2po_high("sat_underrun", 200);
        chk("sat_cnt", 32'(underrun_cnt), 32'(16'hFFFF));
        chk("sat_req", 32'(sect_req), 32'(1));
        chk("sat_lba", 32'(sect_lba), 32'(20'h00001));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
